axi_burst_mem_slave: RTL

AXI4 memory-mapped slave responder with a word-addressed internal RAM, the target end for the team's burst-capable AXI master (`M00_AXI`) that issues write bursts and then reads them back for comparison. It accepts INCR bursts on independent write and read channels, returns OKAY or SLVERR responses, and replaces the verification slave model in self-contained system simulations and on-FPGA loopback tests.

---
 rtl/axi_burst_mem_slave.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/axi_burst_mem_slave.sv
// AXI4 burst memory slave: INCR-only 4-byte beats, one outstanding burst per
// direction, word-addressed RAM, OKAY/SLVERR responses on range or WLAST errors.
module axi_burst_mem_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int MEM_DEPTH_WORDS    = 64
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                      S_AXI_AWLEN,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WLAST,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]                      S_AXI_ARLEN,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RLAST,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  localparam int IDX_W  = C_S_AXI_ADDR_WIDTH - 2;
  localparam int MEM_AW = $clog2(MEM_DEPTH_WORDS);
  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return (idx < IDX_W'(MEM_DEPTH_WORDS));
  endfunction

  logic [C_S_AXI_DATA_WIDTH-1:0] mem_r [MEM_DEPTH_WORDS];

  w_state_t                      w_state_r;
  logic [IDX_W-1:0]              waddr_r;
  logic [7:0]                    wlen_r;
  logic [7:0]                    wcnt_r;
  logic                          werr_r;
  logic                          awready_r;
  logic                          wready_r;
  logic                          bvalid_r;
  logic [1:0]                    bresp_r;

  r_state_t                      r_state_r;
  logic [IDX_W-1:0]              raddr_r;
  logic [7:0]                    rlen_r;
  logic [7:0]                    rcnt_r;
  logic                          arready_r;
  logic                          rvalid_r;
  logic                          rlast_r;
  logic [1:0]                    rresp_r;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_r;

  logic                          w_beat_s;
  logic                          w_last_s;
  logic                          w_inrange_s;
  logic                          w_err_s;
  logic                          mem_we_s;
  logic                          ar_hs_s;
  logic                          r_beat_s;
  logic [IDX_W-1:0]              fetch_idx_s;
  logic                          fetch_ok_s;
  logic [C_S_AXI_DATA_WIDTH-1:0] fetch_data_s;
  logic                          unused_ok_s;

  assign unused_ok_s = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Write-beat decode: the error flag accumulates range and WLAST-position faults.
  always_comb begin
    w_beat_s    = S_AXI_WVALID && wready_r;
    w_last_s    = (wcnt_r == wlen_r);
    w_inrange_s = in_range(waddr_r);
    mem_we_s    = w_beat_s && w_inrange_s;
    w_err_s     = werr_r || !w_inrange_s || (S_AXI_WLAST != w_last_s);
  end

  // Byte-enabled RAM write port; contents are deliberately not reset.
  always_ff @(posedge ACLK) begin
    if (mem_we_s) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (S_AXI_WSTRB[i]) begin
          mem_r[waddr_r[MEM_AW-1:0]][8*i +: 8] <= S_AXI_WDATA[8*i +: 8];
        end
      end
    end
  end

  // Write FSM: exactly AWLEN+1 beats are consumed regardless of WLAST.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state_r <= W_IDLE;
      waddr_r   <= {IDX_W{1'b0}};
      wlen_r    <= 8'd0;
      wcnt_r    <= 8'd0;
      werr_r    <= 1'b0;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      bresp_r   <= RESP_OKAY;
    end else begin
      case (w_state_r)
        W_IDLE: begin
          awready_r <= 1'b1;
          if (S_AXI_AWVALID && awready_r) begin
            waddr_r   <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
            wlen_r    <= S_AXI_AWLEN;
            wcnt_r    <= 8'd0;
            werr_r    <= 1'b0;
            awready_r <= 1'b0;
            wready_r  <= 1'b1;
            w_state_r <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_beat_s) begin
            waddr_r <= waddr_r + IDX_W'(1);
            wcnt_r  <= wcnt_r + 8'd1;
            werr_r  <= w_err_s;
            if (w_last_s) begin
              wready_r  <= 1'b0;
              bvalid_r  <= 1'b1;
              bresp_r   <= w_err_s ? RESP_SLVERR : RESP_OKAY;
              w_state_r <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            bvalid_r  <= 1'b0;
            bresp_r   <= RESP_OKAY;
            werr_r    <= 1'b0;
            awready_r <= 1'b1;
            w_state_r <= W_IDLE;
          end
        end
        default: begin
          w_state_r <= W_IDLE;
          awready_r <= 1'b0;
          wready_r  <= 1'b0;
          bvalid_r  <= 1'b0;
        end
      endcase
    end
  end

  // Read fetch address: AR address while idle, otherwise the next beat's address.
  always_comb begin
    ar_hs_s      = S_AXI_ARVALID && arready_r;
    r_beat_s     = rvalid_r && S_AXI_RREADY;
    fetch_idx_s  = (r_state_r == R_IDLE) ? S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2] : raddr_r;
    fetch_ok_s   = in_range(fetch_idx_s);
    fetch_data_s = fetch_ok_s ? mem_r[fetch_idx_s[MEM_AW-1:0]] : {C_S_AXI_DATA_WIDTH{1'b0}};
  end

  // Read FSM: beat registers only advance on a handshake, so they hold under stall.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state_r <= R_IDLE;
      raddr_r   <= {IDX_W{1'b0}};
      rlen_r    <= 8'd0;
      rcnt_r    <= 8'd0;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rlast_r   <= 1'b0;
      rresp_r   <= RESP_OKAY;
      rdata_r   <= {C_S_AXI_DATA_WIDTH{1'b0}};
    end else begin
      case (r_state_r)
        R_IDLE: begin
          arready_r <= 1'b1;
          if (ar_hs_s) begin
            rdata_r   <= fetch_data_s;
            rresp_r   <= fetch_ok_s ? RESP_OKAY : RESP_SLVERR;
            rlast_r   <= (S_AXI_ARLEN == 8'd0);
            raddr_r   <= fetch_idx_s + IDX_W'(1);
            rlen_r    <= S_AXI_ARLEN;
            rcnt_r    <= 8'd0;
            rvalid_r  <= 1'b1;
            arready_r <= 1'b0;
            r_state_r <= R_DATA;
          end
        end
        R_DATA: begin
          if (r_beat_s) begin
            if (rlast_r) begin
              rvalid_r  <= 1'b0;
              rlast_r   <= 1'b0;
              arready_r <= 1'b1;
              r_state_r <= R_IDLE;
            end else begin
              rdata_r <= fetch_data_s;
              rresp_r <= fetch_ok_s ? RESP_OKAY : RESP_SLVERR;
              rlast_r <= ((rcnt_r + 8'd1) == rlen_r);
              raddr_r <= raddr_r + IDX_W'(1);
              rcnt_r  <= rcnt_r + 8'd1;
            end
          end
        end
        default: begin
          r_state_r <= R_IDLE;
          arready_r <= 1'b0;
          rvalid_r  <= 1'b0;
          rlast_r   <= 1'b0;
        end
      endcase
    end
  end

  assign S_AXI_AWREADY = awready_r;
  assign S_AXI_WREADY  = wready_r;
  assign S_AXI_BVALID  = bvalid_r;
  assign S_AXI_BRESP   = bresp_r;
  assign S_AXI_ARREADY = arready_r;
  assign S_AXI_RVALID  = rvalid_r;
  assign S_AXI_RLAST   = rlast_r;
  assign S_AXI_RRESP   = rresp_r;
  assign S_AXI_RDATA   = rdata_r;

endmodule
